// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Handshaked ALU: AND/OR/ADD/SLT/XOR in one cycle, iterative shift-add MUL,
// registered result and carry/overflow/zero flags, valid/ready on both sides.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             ainvert,
  input  logic             binvert,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SLT = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     res_q;
  logic                 cout_q;
  logic                 ovf_q;
  logic                 zero_q;
  logic                 vld_q;

  logic                 accept_d;
  logic [WIDTH-1:0]     ap_d;
  logic [WIDTH-1:0]     bp_d;
  logic [WIDTH:0]       sum_d;
  logic                 add_ovf_d;
  logic [WIDTH-1:0]     alu_res_d;
  logic                 alu_cout_d;
  logic                 alu_ovf_d;
  logic [WIDTH:0]       mul_sum_d;
  logic [2*WIDTH-1:0]   acc_step_d;

  // Ready while idle, or while the held result is being taken this cycle.
  assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept_d = in_valid && in_ready;

  assign out_valid = vld_q;
  assign result    = res_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

  // Single-cycle datapath on the live inputs, captured at the acceptance edge.
  always_comb begin
    ap_d       = ainvert ? ~a : a;
    bp_d       = binvert ? ~b : b;
    sum_d      = {1'b0, ap_d} + {1'b0, bp_d} + {{WIDTH{1'b0}}, cin};
    add_ovf_d  = (ap_d[WIDTH-1] == bp_d[WIDTH-1]) && (sum_d[WIDTH-1] != ap_d[WIDTH-1]);
    alu_res_d  = '0;
    alu_cout_d = 1'b0;
    alu_ovf_d  = 1'b0;
    case (op)
      OP_AND: alu_res_d = ap_d & bp_d;
      OP_OR:  alu_res_d = ap_d | bp_d;
      OP_XOR: alu_res_d = ap_d ^ bp_d;
      OP_ADD: begin
        alu_res_d  = sum_d[WIDTH-1:0];
        alu_cout_d = sum_d[WIDTH];
        alu_ovf_d  = add_ovf_d;
      end
      OP_SLT: begin
        alu_res_d  = {{(WIDTH-1){1'b0}}, sum_d[WIDTH-1] ^ add_ovf_d};
        alu_cout_d = sum_d[WIDTH];
        alu_ovf_d  = add_ovf_d;
      end
      default: ;
    endcase
  end

  // One shift-add step: add the multiplicand into the high half when the
  // multiplier LSB is set, then shift the whole accumulator right by one.
  always_comb begin
    mul_sum_d  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                 (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    acc_step_d = {mul_sum_d, acc_q[WIDTH-1:1]};
  end

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else if (accept_d) begin
      if (op == OP_MUL) begin
        acc_q   <= {{WIDTH{1'b0}}, bp_d};
        mcand_q <= ap_d;
        cnt_q   <= '0;
        vld_q   <= 1'b0;
        state_q <= S_MUL;
      end else begin
        res_q   <= alu_res_d;
        cout_q  <= alu_cout_d;
        ovf_q   <= alu_ovf_d;
        zero_q  <= (alu_res_d == '0);
        vld_q   <= 1'b1;
        state_q <= S_DONE;
      end
    end else begin
      case (state_q)
        S_MUL: begin
          if (cnt_q == CNT_LAST) begin
            res_q   <= acc_q[WIDTH-1:0];
            cout_q  <= |acc_q[2*WIDTH-1:WIDTH];
            ovf_q   <= |acc_q[2*WIDTH-1:WIDTH];
            zero_q  <= (acc_q[WIDTH-1:0] == '0);
            vld_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            acc_q <= acc_step_d;
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            vld_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Directed self-checking bench for alu_seq (WIDTH = 32) with a result
// scoreboard filled at issue time and drained when results appear.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin, ainvert, binvert;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout, overflow, zero;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .ainvert(ainvert), .binvert(binvert), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .overflow(overflow), .zero(zero)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain wide arithmetic, signed range test for overflow.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic ci, input logic ai, input logic bi);
    exp_t        e;
    logic [W-1:0] ap, bp;
    logic [63:0] us, prod;
    longint      ss;
    ap = ai ? ~av : av;
    bp = bi ? ~bv : bv;
    us = {32'd0, ap} + {32'd0, bp} + {63'd0, ci};
    ss = longint'($signed(ap)) + longint'($signed(bp)) + longint'(ci);
    prod = {32'd0, ap} * {32'd0, bp};
    e = '0;
    case (o)
      3'd0: e.res = ap & bp;
      3'd1: e.res = ap | bp;
      3'd4: e.res = ap ^ bp;
      3'd2, 3'd3: begin
        e.c   = us[32];
        e.v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        e.res = (o == 3'd2) ? us[31:0] : ((ss < 0) ? 32'd1 : 32'd0);
      end
      3'd5: begin
        e.res = prod[31:0];
        e.c   = (prod[63:32] != 0);
        e.v   = (prod[63:32] != 0);
      end
      default: ;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  task automatic drive(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic ai, input logic bi);
    op = o; a = av; b = bv; cin = ci; ainvert = ai; binvert = bi;
    in_valid = 1'b1;
    sb.push_back(model(o, av, bv, ci, ai, bi));
  endtask

  task automatic check_out(input string tag, input bit pop);
    exp_t e;
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed a result, expected nothing queued", tag);
    end else begin
      e = sb[0];
      check({tag, "_result"},   64'(result),   64'(e.res));
      check({tag, "_cout"},     64'(cout),     64'(e.c));
      check({tag, "_overflow"}, 64'(overflow), 64'(e.v));
      check({tag, "_zero"},     64'(zero),     64'(e.z));
      if (pop) void'(sb.pop_front());
    end
  endtask

  task automatic wait_valid(input string tag, input int maxc);
    int n = 0;
    while (out_valid !== 1'b1 && n < maxc) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, 64'(out_valid === 1'b1), 64'd1);
  endtask

  initial begin
    bit stale;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; ainvert = 1'b0; binvert = 1'b0; op = 3'd0;

    // Reset state
    repeat (3) step();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    rst_n = 1'b1;
    step();
    check("rdy_after_rst", 64'(in_ready), 64'd1);

    // ADD 5 + 7, latency 1
    drive(3'd2, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
    step(); in_valid = 1'b0;
    check_out("add57", 1'b1);
    check("add57_const", 64'(result), 64'd12);
    step();
    check("idle_after_add", 64'(out_valid), 64'd0);

    // SUB and SLT via binvert + cin
    drive(3'd2, 32'd5, 32'd7, 1'b1, 1'b0, 1'b1);
    step(); in_valid = 1'b0;
    check_out("sub", 1'b1);
    check("sub_const", 64'(result), 64'hFFFF_FFFE);
    step();
    drive(3'd3, 32'd5, 32'd7, 1'b1, 1'b0, 1'b1);
    step(); in_valid = 1'b0;
    check_out("slt", 1'b1);
    check("slt_const", 64'(result), 64'd1);
    step();

    // Signed overflow and carry-out boundaries
    drive(3'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0);
    step(); in_valid = 1'b0;
    check_out("add_ovf", 1'b1);
    check("add_ovf_const", 64'(overflow), 64'd1);
    step();
    drive(3'd2, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0);
    step(); in_valid = 1'b0;
    check_out("add_carry", 1'b1);
    check("add_carry_zero", 64'(zero), 64'd1);
    step();

    // NOR through AND with both inverts, then a reserved op
    drive(3'd0, 32'h0000_FF00, 32'h00F0_000F, 1'b0, 1'b1, 1'b1);
    step(); in_valid = 1'b0;
    check_out("nor", 1'b1);
    check("nor_const", 64'(result), 64'hFF0F_00F0);
    step();
    drive(3'd6, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 1'b0);
    step(); in_valid = 1'b0;
    check_out("rsvd", 1'b1);
    step();

    // MUL 6 * 7: in_ready low while iterating, result WIDTH+1 edges later
    drive(3'd5, 32'd6, 32'd7, 1'b0, 1'b0, 1'b0);
    step(); in_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      check($sformatf("mul_busy%0d", i), 64'(in_ready), 64'd0);
      step();
    end
    check("mul_not_early", 64'(out_valid), 64'd0);
    step();
    check_out("mul67", 1'b1);
    check("mul67_const", 64'(result), 64'd42);
    step();

    // MUL with a non-zero high half
    drive(3'd5, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    step(); in_valid = 1'b0;
    wait_valid("mul_big", 40);
    check_out("mul_big", 1'b1);
    step();

    // Backpressure: OR held while ignored inputs wiggle
    drive(3'd1, 32'h0000_00F0, 32'h0000_000F, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    step();
    op = 3'd2; a = 32'd123; b = 32'd456;
    for (int i = 0; i < 5; i++) begin
      check_out($sformatf("bp%0d", i), 1'b0);
      check($sformatf("bp_rdy%0d", i), 64'(in_ready), 64'd0);
      a = a + 32'd1;
      step();
    end
    check_out("bp_last", 1'b1);
    check("bp_const", 64'(result), 64'h0000_00FF);

    // Release together with a new op, then sustained back-to-back issue
    out_ready = 1'b1;
    drive(3'd2, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
    step();
    check_out("b2b_add", 1'b1);
    check("b2b_add_const", 64'(result), 64'd2);
    drive(3'd4, 32'hA5A5_A5A5, 32'hFFFF_0000, 1'b0, 1'b0, 1'b0);
    step();
    check_out("b2b_xor", 1'b1);
    drive(3'd0, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0);
    step(); in_valid = 1'b0;
    check_out("b2b_and", 1'b1);
    step();
    check("b2b_drain", 64'(out_valid), 64'd0);

    // Reset in the middle of a MUL discards it
    drive(3'd5, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
    step(); in_valid = 1'b0;
    repeat (10) step();
    check("mid_mul_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_cout", 64'(cout), 64'd0);
    check("abort_ovf", 64'(overflow), 64'd0);
    check("abort_zero", 64'(zero), 64'd0);
    sb.delete();
    step(); step();
    rst_n = 1'b1;
    step();
    check("rdy_after_abort", 64'(in_ready), 64'd1);
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) stale = 1'b1;
      step();
    end
    check("no_stale_result", 64'(stale), 64'd0);

    // Normal operation resumes
    drive(3'd2, 32'd100, 32'd23, 1'b0, 1'b0, 1'b0);
    step(); in_valid = 1'b0;
    check_out("post_rst_add", 1'b1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 32-bit combinational ALU. It keeps the operand-inversion and carry-in model: A' = ainvert ? ~a : a, B' = binvert ? ~b : b. It adds XOR, an iterative shift-add multiply, status flags and valid/ready flow control on both sides. It sits between the register-read stage and write-back in the multi-cycle datapath, and stalls the issuing stage through in_ready while a multiply runs.

## Interface
- WIDTH, 32, operand/result width (>= 4)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation presented
- in_ready  output  1  block accepts operation this cycle
- a, b  input  WIDTH  operands
- cin  input  1  carry-in for ADD/SLT
- ainvert, binvert  input  1  invert a / b before the operation
- op  input  3  0 AND, 1 OR, 2 ADD, 3 SLT, 4 XOR, 5 MUL, 6-7 reserved
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer takes result
- result  output  WIDTH  registered result
- cout  output  1  carry/high-product flag
- overflow  output  1  signed overflow flag
- zero  output  1  result == 0

## Operation
- States: IDLE, MUL, DONE. Reset enters IDLE.
- Acceptance happens on a rising edge with in_valid && in_ready. Operands, op, cin and inverts are captured at that edge.
- in_ready = (state == IDLE) || (state == DONE && out_ready). This is combinational from out_ready and allows back-to-back issue.
- Single-cycle ops (0-4, 6, 7): result and flags are computed from the captured inputs and registered at the acceptance edge. The state goes to DONE.
- MUL: A' and B' are loaded into a 2*WIDTH accumulator, and a counter is cleared. The state goes to MUL.
  - Each cycle in MUL does one shift-add step.
  - After WIDTH steps the result and flags are registered and the state goes to DONE.
- DONE: out_valid = 1. result and flags hold stable until out_ready.
  - out_ready and no new acceptance: go to IDLE.
  - out_ready and a simultaneous acceptance: load the new op directly (DONE or MUL).
- Arithmetic: S = A' + B' + cin, computed WIDTH+1 bits wide.
  - ADD: result = S[WIDTH-1:0]; cout = S[WIDTH]; overflow = (A'[msb] == B'[msb]) && (S[msb] != A'[msb]).
  - SLT: result = {0…, S[msb] ^ overflow}. cout and overflow are as for ADD. Subtraction needs binvert = 1 and cin = 1.
  - AND/OR/XOR: operate on A' and B'. cout = 0, overflow = 0. ainvert = binvert = 1 with AND gives NOR.
  - MUL: unsigned. result = low WIDTH bits of the product; cout = overflow = (high WIDTH bits != 0).
  - Reserved ops: result = 0, cout = 0, overflow = 0, zero = 1.
- zero is always the registered (result == 0).

## Timing
- Reset values: out_valid 0, result 0, cout 0, overflow 0, zero 0, state IDLE. in_ready is 1 from the first cycle after rst_n releases.
- Single-cycle op: out_valid rises at the acceptance edge and is visible in the next cycle. Latency is 1.
- MUL: out_valid rises WIDTH + 1 edges after the acceptance edge. in_ready = 0 throughout MUL.
- Backpressure: with out_ready low, DONE holds indefinitely with outputs unchanged and in_ready = 0.
- Asserting rst_n low mid-MUL or mid-DONE aborts immediately:
  - all outputs return to reset values asynchronously;
  - the in-flight op is discarded and never produces out_valid.
- Input changes while in_ready = 0 are ignored.
- Sustained back-to-back single-cycle ops with out_ready held high give one result per cycle.

## Test plan
- WIDTH=32, ADD a=5 b=7 cin=0, inverts 0 → next cycle result=12, cout=0, overflow=0, zero=0.
- SUB via binvert=1 cin=1, a=5 b=7 → result=0xFFFFFFFE, cout=0, overflow=0. Same setup with SLT → result=1.
- ADD a=0x7FFFFFFF b=1 → result=0x80000000, overflow=1, cout=0. ADD a=0xFFFFFFFF b=1 → result=0, cout=1, zero=1.
- MUL a=6 b=7 → in_ready low for 32 cycles, out_valid 33 cycles after acceptance, result=42, cout=0.
  - MUL a=0x10000 b=0x10000 → result=0, cout=1, overflow=1, zero=1.
- Backpressure: OR a=0xF0 b=0x0F with out_ready=0 for 5 cycles → result=0xFF held, in_ready=0.
  - Then raise out_ready together with a new in_valid ADD 1+1 → result=2 on the next cycle with no bubble.
- Reset: pull rst_n low 10 cycles into a MUL → out_valid=0 and result=0 immediately. After release, in_ready=1 and no stale result appears.
